// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter: FSM encoding
// and the double-dabble digit constants.
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int         BCD_DIGIT_W = 4;
  localparam logic [3:0] ADD3_THRESH = 4'd5;
  localparam logic [3:0] BCD_NINE    = 4'd9;

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Start/busy/done handshake and result bus of the binary-to-BCD converter.
// The requester (score logic / bench) is the master, the converter the slave.
interface bin_to_bcd_seq_if #(
  parameter int BIN_WIDTH = 8,
  parameter int DIGITS    = 3
);
  logic                  start;
  logic [BIN_WIDTH-1:0]  binIn;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcdOut;
  logic                  overflow;

  modport master (
    output start, binIn,
    input  busy, done, bcdOut, overflow
  );

  modport slave (
    input  start, binIn,
    output busy, done, bcdOut, overflow
  );
endinterface

// File: rtl/bcd_add3.sv
// One double-dabble correction cell: a BCD digit of 5 or more gets 3 added so
// the following left shift carries correctly into the next digit.
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] din,
  output logic [BCD_DIGIT_W-1:0] dout
);

  assign dout = (din >= ADD3_THRESH) ? din + 4'd3 : din;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one binary bit per clock, result and
// overflow flag held stable between done pulses.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_WIDTH = 8,
  parameter int DIGITS    = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  bin_to_bcd_seq_if.slave   bus
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_WIDTH) + 1;

  state_t               state_reg;
  logic [BIN_WIDTH-1:0] bin_reg;
  logic [BCD_W-1:0]     bcd_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic                 ovf_acc_reg;
  logic                 busy_reg;
  logic                 done_reg;
  logic [BCD_W-1:0]     bcd_out_reg;
  logic                 overflow_reg;

  logic [BCD_W-1:0]           bcd_adj;
  logic [BCD_W+BIN_WIDTH-1:0] shift_next;
  logic [BCD_W-1:0]           bcd_next;
  logic [BIN_WIDTH-1:0]       bin_next;
  logic                       ovf_next;
  logic                       last_step;
  logic [BCD_W-1:0]           nines;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      bcd_add3 u_add3 (
        .din  (bcd_reg[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
        .dout (bcd_adj[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
      assign nines[gi*BCD_DIGIT_W +: BCD_DIGIT_W] = BCD_NINE;
    end
  endgenerate

  // The bit leaving the top adjusted digit is lost, so it marks overflow.
  assign shift_next = {bcd_adj[BCD_W-2:0], bin_reg, 1'b0};
  assign bcd_next   = shift_next[BCD_W+BIN_WIDTH-1 -: BCD_W];
  assign bin_next   = shift_next[BIN_WIDTH-1:0];
  assign ovf_next   = ovf_acc_reg | bcd_adj[BCD_W-1];
  assign last_step  = (cnt_reg == CNT_W'(BIN_WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      bin_reg      <= '0;
      bcd_reg      <= '0;
      cnt_reg      <= '0;
      ovf_acc_reg  <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      bcd_out_reg  <= '0;
      overflow_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          done_reg <= 1'b0;
          if (bus.start) begin
            bin_reg     <= bus.binIn;
            bcd_reg     <= '0;
            ovf_acc_reg <= 1'b0;
            cnt_reg     <= '0;
            busy_reg    <= 1'b1;
            state_reg   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          bcd_reg     <= bcd_next;
          bin_reg     <= bin_next;
          ovf_acc_reg <= ovf_next;
          cnt_reg     <= cnt_reg + 1'b1;
          if (last_step) begin
            busy_reg     <= 1'b0;
            done_reg     <= 1'b1;
            bcd_out_reg  <= ovf_next ? nines : bcd_next;
            overflow_reg <= ovf_next;
            state_reg    <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;
  assign bus.bcdOut   = bcd_out_reg;
  assign bus.overflow = overflow_reg;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: default 8-bit/3-digit instance, a 2-digit
// instance for overflow, and the bcd_add3 cell on its own.
module tb_bin_to_bcd_seq;
  import bcd_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   sel;

  bin_to_bcd_seq_if #(.BIN_WIDTH(8), .DIGITS(3)) bus0 ();
  bin_to_bcd_seq_if #(.BIN_WIDTH(8), .DIGITS(2)) bus1 ();

  bin_to_bcd_seq #(.BIN_WIDTH(8), .DIGITS(3)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0.slave)
  );

  bin_to_bcd_seq #(.BIN_WIDTH(8), .DIGITS(2)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  logic [3:0] add_in;
  logic [3:0] add_out;

  bcd_add3 u_cell (
    .din  (add_in),
    .dout (add_out)
  );

  logic        m_busy;
  logic        m_done;
  logic [11:0] m_bcd;
  logic        m_ovf;

  assign m_busy = (sel == 0) ? bus0.busy     : bus1.busy;
  assign m_done = (sel == 0) ? bus0.done     : bus1.done;
  assign m_bcd  = (sel == 0) ? bus0.bcdOut   : {4'd0, bus1.bcdOut};
  assign m_ovf  = (sel == 0) ? bus0.overflow : bus1.overflow;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] ref_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic drive_start(input int which, input logic s, input logic [7:0] v);
    if (which == 0) begin
      bus0.start = s;
      bus0.binIn = v;
    end else begin
      bus1.start = s;
      bus1.binIn = v;
    end
  endtask

  // One full conversion with cycle-exact handshake checks.
  task automatic run_conv(input int which, input logic [7:0] v,
                          output logic [11:0] res, output logic ovf);
    sel = which;
    @(negedge clk);
    drive_start(which, 1'b1, v);
    @(posedge clk); #1;
    drive_start(which, 1'b0, v);
    check("busy_after_accept", {31'd0, m_busy}, 32'd1);
    repeat (7) begin
      @(posedge clk); #1;
      check("no_early_done", {31'd0, m_done}, 32'd0);
    end
    @(posedge clk); #1;
    check("done_at_latency", {31'd0, m_done}, 32'd1);
    check("busy_low_at_done", {31'd0, m_busy}, 32'd0);
    res = m_bcd;
    ovf = m_ovf;
    @(posedge clk); #1;
    check("done_single_cycle", {31'd0, m_done}, 32'd0);
    check("result_held", {20'd0, m_bcd}, {20'd0, res});
    $display("conv dut%0d bin=%0d bcd=%03h ovf=%0b", which, v, res, ovf);
  endtask

  logic [11:0] res;
  logic        ovf;
  logic [7:0]  sweep_in  [6];
  logic [11:0] sweep_exp [6];

  initial begin
    checks = 0;
    errors = 0;
    sel    = 0;
    add_in = 4'd0;
    bus0.start = 1'b0; bus0.binIn = '0;
    bus1.start = 1'b0; bus1.binIn = '0;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, bus0.busy}, 32'd0);
    check("rst_done", {31'd0, bus0.done}, 32'd0);
    check("rst_bcd", {20'd0, bus0.bcdOut}, 32'h000);
    check("rst_ovf", {31'd0, bus0.overflow}, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Full-scale value
    run_conv(0, 8'd255, res, ovf);
    check("bcd_255", {20'd0, res}, 32'h255);
    check("ovf_255", {31'd0, ovf}, 32'd0);

    // Reset in the middle of a conversion, with a non-zero result on display
    @(negedge clk);
    drive_start(0, 1'b1, 8'd77);
    @(posedge clk); #1;
    drive_start(0, 1'b0, 8'd77);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, bus0.busy}, 32'd0);
    check("midrst_done", {31'd0, bus0.done}, 32'd0);
    check("midrst_bcd", {20'd0, bus0.bcdOut}, 32'h000);
    check("midrst_ovf", {31'd0, bus0.overflow}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      check("idle_busy", {31'd0, bus0.busy}, 32'd0);
      check("idle_done", {31'd0, bus0.done}, 32'd0);
    end

    // Hand-computed sweep
    sweep_in[0] = 8'd0;   sweep_exp[0] = 12'h000;
    sweep_in[1] = 8'd9;   sweep_exp[1] = 12'h009;
    sweep_in[2] = 8'd10;  sweep_exp[2] = 12'h010;
    sweep_in[3] = 8'd99;  sweep_exp[3] = 12'h099;
    sweep_in[4] = 8'd100; sweep_exp[4] = 12'h100;
    sweep_in[5] = 8'd128; sweep_exp[5] = 12'h128;
    for (int i = 0; i < 6; i++) begin
      run_conv(0, sweep_in[i], res, ovf);
      check($sformatf("sweep_%0d", sweep_in[i]), {20'd0, res}, {20'd0, sweep_exp[i]});
    end

    // All 8-bit values against a decimal model
    for (int v = 0; v < 256; v++) begin
      run_conv(0, 8'(v), res, ovf);
      check($sformatf("all_%0d", v), {19'd0, ovf, res}, {20'd0, ref_bcd(v)});
    end

    // start held high; binIn changes while busy
    sel = 0;
    @(negedge clk);
    drive_start(0, 1'b1, 8'd37);
    @(posedge clk); #1;
    drive_start(0, 1'b1, 8'd200);
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      check($sformatf("held_done_%0d", i), {31'd0, bus0.done},
            {31'd0, logic'(i == 8 || i == 18)});
      if (i == 8) begin
        check("held_first", {20'd0, bus0.bcdOut}, 32'h037);
        $display("conv dut0 bin=37 bcd=%03h (start held)", bus0.bcdOut);
      end
      if (i == 10)
        check("held_reaccept_busy", {31'd0, bus0.busy}, 32'd1);
      if (i == 18) begin
        check("held_second", {20'd0, bus0.bcdOut}, 32'h200);
        $display("conv dut0 bin=200 bcd=%03h (start held)", bus0.bcdOut);
        drive_start(0, 1'b0, 8'd200);
      end
    end
    repeat (12) @(posedge clk);

    // Two-digit instance: overflow saturates to 99 and clears on next result
    run_conv(1, 8'd100, res, ovf);
    check("d2_ovf_100", {31'd0, ovf}, 32'd1);
    check("d2_bcd_100", {20'd0, res}, 32'h099);
    run_conv(1, 8'd42, res, ovf);
    check("d2_ovf_42", {31'd0, ovf}, 32'd0);
    check("d2_bcd_42", {20'd0, res}, 32'h042);

    // Correction cell on its own
    for (int i = 0; i < 10; i++) begin
      add_in = 4'(i);
      #1;
      check($sformatf("add3_%0d", i), {28'd0, add_out}, (i < 5) ? i : i + 3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
